// File: rtl/spongent_ctrl.sv
// spongent_ctrl: control sequencer for the SPONGENT hash datapath.
// Absorbs a RATE-bit block stream (one permutation per block), appends the
// single-block padding, then squeezes HASH_SIZE/RATE digest blocks.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, busy                 hash request (IDLE only) / not-IDLE status
//   msg_data/valid/last/ready   message input handshake
//   hash_data/valid/last/ready  digest output handshake
//   dp_*                        SPONGENT datapath controls and status
module spongent_ctrl #(
   parameter int unsigned RATE      = 8,
   parameter int unsigned HASH_SIZE = 128
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   input  logic [RATE-1:0] msg_data,
   input  logic            msg_valid,
   input  logic            msg_last,
   output logic            msg_ready,
   output logic [RATE-1:0] hash_data,
   output logic            hash_valid,
   output logic            hash_last,
   input  logic            hash_ready,
   output logic            dp_reset_state,
   output logic            dp_sample_state,
   output logic            dp_init_lfsr,
   output logic            dp_update_lfsr,
   output logic            dp_select_message,
   input  logic            dp_lfsr_all_1,
   output logic [RATE-1:0] dp_data_in,
   input  logic [RATE-1:0] dp_data_out
);

   localparam int unsigned NUM_OUT = HASH_SIZE / RATE;
   localparam int unsigned CNT_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_INIT         = 3'd1;
   localparam logic [2:0] S_ABSORB_WAIT  = 3'd2;
   localparam logic [2:0] S_ABSORB_PERM  = 3'd3;
   localparam logic [2:0] S_PAD_PERM     = 3'd4;
   localparam logic [2:0] S_SQUEEZE_OUT  = 3'd5;
   localparam logic [2:0] S_SQUEEZE_PERM = 3'd6;

   localparam logic [RATE-1:0] PAD_BLOCK = {1'b1, {(RATE-1){1'b0}}};

   logic [2:0]       state, state_nxt;
   logic             last_seen, last_seen_nxt;
   logic             pad_first, pad_first_nxt;
   logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
   logic             round;
   logic             init_req;
   logic             absorb_end;
   logic             absorb_last;

   // Digest blocks are the datapath rate bits, passed straight through.
   assign hash_data = dp_data_out;

   // State and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         last_seen <= 1'b0;
         pad_first <= 1'b0;
         out_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         last_seen <= last_seen_nxt;
         pad_first <= pad_first_nxt;
         out_cnt   <= out_cnt_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt         = state;
      last_seen_nxt     = last_seen;
      pad_first_nxt     = pad_first;
      out_cnt_nxt       = out_cnt;
      busy              = (state != S_IDLE);
      msg_ready         = 1'b0;
      hash_valid        = 1'b0;
      hash_last         = 1'b0;
      dp_reset_state    = 1'b0;
      dp_select_message = 1'b0;
      dp_data_in        = '0;
      dp_sample_state   = 1'b0;
      dp_init_lfsr      = 1'b0;
      dp_update_lfsr    = 1'b0;
      round             = 1'b0;
      init_req          = 1'b0;
      absorb_end        = 1'b0;
      absorb_last       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_INIT;
         end
         S_INIT: begin
            dp_reset_state = 1'b1;
            init_req       = 1'b1;
            state_nxt      = S_ABSORB_WAIT;
         end
         S_ABSORB_WAIT: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               // Transfer cycle doubles as round 1 of the absorb permutation.
               round             = 1'b1;
               dp_select_message = 1'b1;
               dp_data_in        = msg_data;
               last_seen_nxt     = msg_last;
               state_nxt         = S_ABSORB_PERM;
               absorb_end        = dp_lfsr_all_1;
               absorb_last       = msg_last;
            end
         end
         S_ABSORB_PERM: begin
            round       = 1'b1;
            absorb_end  = dp_lfsr_all_1;
            absorb_last = last_seen;
         end
         S_PAD_PERM: begin
            round         = 1'b1;
            pad_first_nxt = 1'b0;
            if (pad_first) begin
               dp_select_message = 1'b1;
               dp_data_in        = PAD_BLOCK;
            end
            if (dp_lfsr_all_1) begin
               out_cnt_nxt = '0;
               state_nxt   = S_SQUEEZE_OUT;
            end
         end
         S_SQUEEZE_OUT: begin
            hash_valid = 1'b1;
            hash_last  = (out_cnt == CNT_W'(NUM_OUT - 1));
            if (hash_ready) begin
               if (hash_last) begin
                  state_nxt = S_IDLE;
               end else begin
                  out_cnt_nxt = out_cnt + CNT_W'(1);
                  state_nxt   = S_SQUEEZE_PERM;
               end
            end
         end
         S_SQUEEZE_PERM: begin
            round = 1'b1;
            if (dp_lfsr_all_1) state_nxt = S_SQUEEZE_OUT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // End of an absorb permutation: next block, or pad once the last is in.
      if (absorb_end) begin
         if (absorb_last) begin
            state_nxt     = S_PAD_PERM;
            pad_first_nxt = 1'b1;
         end else begin
            state_nxt     = S_ABSORB_WAIT;
         end
      end

      // Round cycle: the final round reloads the LFSR instead of stepping it.
      dp_sample_state = round;
      dp_update_lfsr  = round & ~dp_lfsr_all_1;
      dp_init_lfsr    = init_req | (round & dp_lfsr_all_1);
   end

endmodule

// File: doc/spongent_ctrl.md
# spongent_ctrl

Control sequencer for the SPONGENT hash datapath. It accepts a byte-stream message over a valid/ready handshake, absorbs one RATE-bit block per permutation, and appends the single-block padding after the last block. It then squeezes HASH_SIZE/RATE output blocks over a second valid/ready handshake. It drives every control input of the SPONGENT datapath and monitors its LFSR round flag.

## Interface
- RATE, 8: block width in bits; must equal the datapath rate.
- HASH_SIZE, 128: digest size in bits; must be a multiple of RATE. NUM_OUT = HASH_SIZE/RATE.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a new hash; ignored unless in IDLE.
- busy  out  1  high in every state except IDLE.
- msg_data  in  RATE  message block.
- msg_valid  in  1  msg_data valid.
- msg_last  in  1  qualifies the final message block; sampled with msg_valid.
- msg_ready  out  1  high only in ABSORB_WAIT.
- hash_data  out  RATE  digest block; equals dp_data_out.
- hash_valid  out  1  high only in SQUEEZE_OUT.
- hash_last  out  1  high with hash_valid on block NUM_OUT-1.
- hash_ready  in  1  consumer accepts hash_data.
- dp_reset_state, dp_sample_state, dp_init_lfsr, dp_update_lfsr, dp_select_message  out  1 each  datapath controls.
- dp_lfsr_all_1  in  1  datapath flag: the LFSR holds all-ones, so the current round is the last of the permutation.
- dp_data_in  out  RATE  datapath message input.
- dp_data_out  in  RATE  datapath rate bits.

## Operation
- States: IDLE, INIT, ABSORB_WAIT, ABSORB_PERM, PAD_PERM, SQUEEZE_OUT, SQUEEZE_PERM.
- Registers: state; flag last_seen; flag pad_first; squeeze counter out_cnt of width clog2(NUM_OUT), minimum 1.
- Outputs are decoded from state and flags. No output depends combinationally on msg_valid or hash_ready, except the transfer-cycle outputs listed below.
- Round cycle: dp_sample_state=1. Then either:
  - dp_lfsr_all_1=0: dp_update_lfsr=1 and dp_init_lfsr=0; or
  - dp_lfsr_all_1=1: last round, dp_update_lfsr=0 and dp_init_lfsr=1, so the LFSR is reloaded for the next permutation.
- dp_init_lfsr and dp_update_lfsr are never high together.
- IDLE: all outputs 0. start=1 moves to INIT.
- INIT, one cycle: dp_reset_state=1 and dp_init_lfsr=1. Then go to ABSORB_WAIT.
- ABSORB_WAIT: msg_ready=1.
  - On msg_valid=1, the transfer cycle is round 1: dp_select_message=1, dp_data_in=msg_data, and last_seen<=msg_last.
  - Go to ABSORB_PERM. If this round is also the last round, apply the end-of-permutation rule below directly.
- ABSORB_PERM: round cycles with dp_select_message=0 until the last round.
- End of an absorb permutation: last_seen=0 goes to ABSORB_WAIT; last_seen=1 goes to PAD_PERM with pad_first<=1.
- PAD_PERM:
  - First round: dp_select_message=1, dp_data_in = {1'b1, (RATE-1)'b0}.
  - Remaining rounds: plain round cycles.
  - After the last round: out_cnt<=0, go to SQUEEZE_OUT.
- SQUEEZE_OUT: hash_valid=1, no datapath controls asserted.
  - On hash_ready with out_cnt==NUM_OUT-1 (hash_last=1): go to IDLE.
  - Otherwise: out_cnt+1, go to SQUEEZE_PERM.
- SQUEEZE_PERM: round cycles with dp_select_message=0. After the last round, go to SQUEEZE_OUT.
- dp_data_in is 0 whenever dp_select_message=0.
- Messages are at least one block long. Empty-message hashing is out of scope.
- rst_n low at any time forces IDLE and clears all registers. The datapath state is not valid afterwards; the next start re-initialises it through INIT.

## Timing
- Reset values: all outputs 0 and busy=0.
- Latency:
  - start at cycle t: INIT at t+1, msg_ready=1 from t+2.
  - A permutation takes R cycles, including the transfer cycle for absorb blocks. R=70 with default datapath parameters.
  - After the last message block is transferred at cycle a, the first hash_valid occurs at a+2R.
- No idle cycle between a permutation's last round and the next state.
- Stalls:
  - msg_valid=0 in ABSORB_WAIT and hash_ready=0 in SQUEEZE_OUT hold the state.
  - dp_sample_state=0 during a stall; hash_data stays stable.
- busy falls the cycle after the hash_last transfer. start in that cycle is legal.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release with no start -> IDLE is held and busy=0.
- Single block 0x00 with msg_last=1, hash_ready=1 ->
  - msg_ready for exactly one transfer;
  - 70 absorb cycles plus 70 pad cycles;
  - 16 hash beats separated by 70-cycle permutations;
  - hash_last only on beat 16;
  - digest matches the golden SPONGENT-128/128/8 model.
- Three-block message with 5-cycle msg_valid gaps and hash_ready toggling every other cycle -> digest matches the model; no dp_sample_state during stalls; hash_data stable while hash_valid=1 and hash_ready=0.
- start pulsed while in ABSORB_PERM -> ignored and the digest is unchanged. Back-to-back hashes with start the cycle after hash_last -> both digests are correct.
- rst_n pulsed low mid-PAD_PERM -> IDLE immediately with outputs 0. A subsequent start and message 0xAB -> correct digest.
- Assertions throughout:
  - dp_init_lfsr and dp_update_lfsr are never both high.
  - dp_select_message occurs only on an absorb transfer cycle or the first PAD_PERM round.
  - dp_data_in=0 whenever dp_select_message=0.
